cordic_full_range: RTL and testbench

Full-circle front/back end for the iterative `cordic` core. It accepts a rotation or vectoring request over the whole plane, folds it into the core's ±π/2 convergence range, and pre-scales the operands by ½ to leave headroom. It then runs the core through its start/done handshake and undoes the fold. Results are gain-compensated (×2K), so callers see true-magnitude results in full-circle angle units behind a valid/ready interface.

---
 rtl/cordic_full_range.sv | 163 ++++++++++++++++
 tb/tb_cordic_full_range.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_full_range.sv
// Full-circle front/back end for the iterative cordic core. It folds each request into the
// core's +/-pi/2 range with 1/2 headroom, runs the core, then unfolds and applies the 2K gain.
module cordic_full_range #(
  parameter logic [31:0] GAIN_Q30 = 32'd1304065748
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_angle,
  output logic        cordic_reset,
  output logic        cordic_start,
  output logic        cordic_mode,
  output logic [31:0] cordic_angle,
  output logic [31:0] cordic_x,
  output logic [31:0] cordic_y,
  input  logic        cordic_done,
  input  logic [31:0] cordic_out_x,
  input  logic [31:0] cordic_out_y,
  input  logic [31:0] cordic_out_angle,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_SCALE_X = 3'd2,
    S_SCALE_Y = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rst_sr_q;
  logic               done_q;
  logic               mode_q;
  logic               f_q;
  logic [31:0]        echo_q;
  logic [31:0]        cangle_q;
  logic signed [31:0] cx_q, cy_q;
  logic signed [31:0] cap_x_q, cap_y_q, cap_a_q;
  logic [31:0]        out_x_q, out_y_q, out_angle_q;

  logic               fold;
  logic signed [31:0] xh, yh;
  logic [31:0]        theta_f;
  logic               done_rise;
  logic signed [31:0] mul_a;
  logic signed [63:0] prod, rnd;
  logic [31:0]        sat_r;
  logic [31:0]        vec_angle;

  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE (and not during core reset), out_valid only in HOLD.
  assign in_ready     = (state_q == S_IDLE) && !rst_sr_q[1];
  assign out_valid    = (state_q == S_HOLD);
  assign cordic_start = (state_q == S_LAUNCH);
  assign cordic_reset = rst_sr_q[1];
  assign cordic_mode  = mode_q;
  assign cordic_angle = cangle_q;
  assign cordic_x     = cx_q;
  assign cordic_y     = cy_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_angle    = out_angle_q;
  assign dbg_state    = state_q;

  // A folded rotation is rotated by theta-pi with the input vector negated.
  assign fold      = in_mode ? in_x[31] : (in_angle[31] ^ in_angle[30]);
  assign xh        = $signed(in_x) >>> 1;
  assign yh        = $signed(in_y) >>> 1;
  assign theta_f   = fold ? (in_angle ^ 32'h8000_0000) : in_angle;
  assign done_rise = cordic_done && !done_q;

  assign mul_a = (state_q == S_SCALE_Y) ? cap_y_q : cap_x_q;
  assign prod  = 64'(mul_a) * $signed({32'd0, GAIN_Q30});
  assign rnd   = (prod + 64'sd536870912) >>> 30;

  always_comb begin
    sat_r = rnd[31:0];
    if (rnd > 64'sd2147483647)
      sat_r = 32'h7FFF_FFFF;
    else if (rnd < -64'sd2147483648)
      sat_r = 32'h8000_0000;
  end

  assign vec_angle = 32'(cap_a_q >>> 1) + (f_q ? 32'h8000_0000 : 32'h0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (in_valid && in_ready) state_d = S_LAUNCH;
      S_LAUNCH:  if (done_rise) state_d = S_SCALE_X;
      S_SCALE_X: state_d = S_SCALE_Y;
      S_SCALE_Y: state_d = S_HOLD;
      S_HOLD:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rst_sr_q <= 2'b11;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rst_sr_q <= {rst_sr_q[0], 1'b0};
      done_q   <= cordic_done;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 1'b0;
      f_q         <= 1'b0;
      echo_q      <= '0;
      cangle_q    <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      cap_x_q     <= '0;
      cap_y_q     <= '0;
      cap_a_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_angle_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mode_q   <= in_mode;
            f_q      <= fold;
            echo_q   <= in_angle;
            cx_q     <= fold ? -xh : xh;
            cy_q     <= fold ? -yh : yh;
            cangle_q <= in_mode ? 32'h0 : {theta_f[30:0], 1'b0};
          end
        end
        S_LAUNCH: begin
          if (done_rise) begin
            cap_x_q <= $signed(cordic_out_x);
            cap_y_q <= $signed(cordic_out_y);
            cap_a_q <= $signed(cordic_out_angle);
          end
        end
        S_SCALE_X: out_x_q <= sat_r;
        S_SCALE_Y: begin
          out_y_q     <= sat_r;
          out_angle_q <= mode_q ? vec_angle : echo_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_full_range.sv
// Bench for cordic_full_range: an ideal floating-point core stands in for cordic, and a
// real-arithmetic scoreboard predicts the full-circle results of every request.
module tb_cordic_full_range;

  localparam real PI = 3.141592653589793;
  localparam real K  = 0.6072529350088812;
  localparam int  TOL_XY  = 10000;
  localparam int  TOL_ANG = 1 << 20;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [31:0] in_x, in_y, in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x, out_y, out_angle;
  logic        cordic_reset, cordic_start, cordic_mode;
  logic [31:0] cordic_angle, cordic_x, cordic_y;
  logic        cordic_done;
  logic [31:0] cordic_out_x, cordic_out_y, cordic_out_angle;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;
  logic [31:0] got_x, got_y, got_a;

  // {mode, x, y, angle}
  logic [96:0] exp_q[$];

  cordic_full_range dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_angle(out_angle),
    .cordic_reset(cordic_reset), .cordic_start(cordic_start), .cordic_mode(cordic_mode),
    .cordic_angle(cordic_angle), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_done(cordic_done),
    .cordic_out_x(cordic_out_x), .cordic_out_y(cordic_out_y),
    .cordic_out_angle(cordic_out_angle),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] sat32(input real r);
    real q;
    q = (r >= 0.0) ? r + 0.5 : r - 0.5;
    if (q > 2147483647.0) return 32'h7FFF_FFFF;
    if (q < -2147483648.0) return 32'h8000_0000;
    return $rtoi(q);
  endfunction

  function automatic logic [96:0] model(input logic mode, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] a);
    real xr, yr, th, ox, oy, oa;
    logic [31:0] ea;
    xr = real'($signed(x));
    yr = real'($signed(y));
    if (!mode) begin
      th = real'($signed(a)) * PI / 2147483648.0;
      ox = xr * $cos(th) - yr * $sin(th);
      oy = xr * $sin(th) + yr * $cos(th);
      ea = a;
    end else begin
      ox = $sqrt(xr * xr + yr * yr);
      oy = 0.0;
      oa = $atan2(yr, xr) * 2147483648.0 / PI;
      if (oa >= 2147483648.0) oa = oa - 4294967296.0;
      ea = sat32(oa);
    end
    return {mode, sat32(ox), sat32(oy), ea};
  endfunction

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                           input longint tol, input bit wrap);
    longint d;
    tests++;
    if (wrap) d = longint'($signed(act - exp_v));
    else      d = longint'($signed(act)) - longint'($signed(exp_v));
    if (d < 0) d = -d;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) tol %0d",
               name, $signed(act), act, $signed(exp_v), exp_v, tol);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  // ---------------- ideal core stand-in ----------------
  task automatic core_run();
    real cx, cy, phi, ox, oy, oa;
    int lat;
    bit aborted;
    cx  = real'($signed(cordic_x));
    cy  = real'($signed(cordic_y));
    phi = real'($signed(cordic_angle)) * PI / 4294967296.0;
    if (!cordic_mode) begin
      ox = (cx * $cos(phi) - cy * $sin(phi)) / K;
      oy = (cx * $sin(phi) + cy * $cos(phi)) / K;
      oa = 0.0;
    end else begin
      ox = $sqrt(cx * cx + cy * cy) / K;
      oy = 0.0;
      oa = $atan2(cy, cx) * 4294967296.0 / PI;
    end
    lat = $urandom_range(1, 8);
    aborted = 1'b0;
    @(posedge clk); #1;
    cordic_done = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      if (!reset_n || !cordic_start) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      cordic_done = 1'b0;
    end else begin
      cordic_out_x     = sat32(ox);
      cordic_out_y     = sat32(oy);
      cordic_out_angle = sat32(oa);
      cordic_done      = 1'b1;
      done_cyc         = cyc;
    end
  endtask

  initial begin
    cordic_done      = 1'b0;
    cordic_out_x     = '0;
    cordic_out_y     = '0;
    cordic_out_angle = '0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && !cordic_reset && cordic_start) core_run();
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [96:0] e;
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: out_valid with empty expected queue, out_x=%0d", $signed(out_x));
      end else begin
        e = exp_q[0];
        check_tol("sb_out_x", out_x, e[95:64], TOL_XY, 1'b0);
        check_tol("sb_out_y", out_y, e[63:32], TOL_XY, 1'b0);
        check_tol("sb_out_angle", out_angle, e[31:0], e[96] ? TOL_ANG : 0, 1'b1);
        check_bit("sb_in_ready_low_in_hold", in_ready, 1'b0);
        check_bit("sb_start_low_in_hold", cordic_start, 1'b0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic mode, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] a);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_bit("send_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_x     = x;
    in_y     = y;
    in_angle = a;
    exp_q.push_back(model(mode, x, y, a));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x     = $urandom;
    in_y     = $urandom;
    in_angle = $urandom;
  endtask

  task automatic wait_result(input int hold);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      n++;
    end
    check_bit("result_timeout", seen, 1'b1);
    tests++;
    if (seen && cyc != done_cyc + 3) begin
      fails++;
      $display("FAIL latency: out_valid after edge %0d, core done raised after edge %0d (want +3)",
               cyc, done_cyc);
    end
    got_x = out_x;
    got_y = out_y;
    got_a = out_angle;
    // A request offered during HOLD must be ignored.
    for (int i = 0; i < hold + 1; i++) begin
      @(posedge clk); #1;
      if (hold > 0 && i < hold) begin
        in_valid = 1'b1;
        in_mode  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_bit("out_valid_drops", out_valid, 1'b0);
    check_bit("in_ready_after_handshake", in_ready, 1'b1);
  endtask

  task automatic run(input logic mode, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] a, input int hold);
    send(mode, x, y, a);
    wait_result(hold);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_angle  = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_cordic_start", cordic_start, 1'b0);
    check_bit("rst_cordic_reset", cordic_reset, 1'b1);
    check_tol("rst_out_x", out_x, 32'd0, 0, 1'b0);
    check_tol("rst_cordic_x", cordic_x, 32'd0, 0, 1'b0);

    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_bit("cordic_reset_edge1", cordic_reset, 1'b1);
    check_bit("in_ready_edge1", in_ready, 1'b0);
    @(posedge clk); #1;
    check_bit("cordic_reset_edge2", cordic_reset, 1'b0);
    check_bit("in_ready_edge2", in_ready, 1'b1);

    // Rotation by pi/2 (folded path)
    run(1'b0, 32'h4000_0000, 32'h0, 32'h4000_0000, 0);
    check_tol("rot90_x", got_x, 32'd0, TOL_XY, 1'b0);
    check_tol("rot90_y", got_y, 32'h4000_0000, TOL_XY, 1'b0);
    check_tol("rot90_angle", got_a, 32'h4000_0000, 0, 1'b0);

    // Rotation by -pi
    run(1'b0, 32'h4000_0000, 32'h0, 32'h8000_0000, 0);
    check_tol("rot180_x", got_x, 32'hC000_0000, TOL_XY, 1'b0);
    check_tol("rot180_y", got_y, 32'd0, TOL_XY, 1'b0);

    // Vectoring in the second quadrant
    run(1'b1, 32'hC000_0000, 32'h4000_0000, 32'h0, 0);
    check_tol("vec135_x", got_x, 32'd1518500250, TOL_XY, 1'b0);
    check_tol("vec135_angle", got_a, 32'd1610612736, TOL_ANG, 1'b1);

    // Vectoring on the negative x axis
    run(1'b1, 32'hC000_0000, 32'h0, 32'h0, 0);
    check_tol("vec180_x", got_x, 32'h4000_0000, TOL_XY, 1'b0);
    check_tol("vec180_angle", got_a, 32'h8000_0000, TOL_ANG, 1'b1);

    // Saturation, with 10 cycles of backpressure in HOLD
    run(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2000_0000, 10);
    check_tol("sat_y", got_y, 32'h7FFF_FFFF, 0, 1'b0);
    check_tol("sat_x", got_x, 32'd0, TOL_XY, 1'b0);

    // Further directed vectors, checked by the scoreboard
    run(1'b0, 32'd123456789, -32'sd987654321, 32'h0000_0000, 0);
    run(1'b0, 32'd300000000, 32'd200000000, 32'hE000_0000, 2);
    run(1'b0, -32'sd400000000, 32'd100000000, 32'hC000_0000, 0);
    run(1'b0, 32'd500000000, -32'sd250000000, 32'h6000_0000, 1);
    run(1'b0, 32'd700000000, 32'd0, 32'hA000_0000, 0);
    run(1'b1, 32'd1000000, -32'sd2000000, 32'h0, 0);
    run(1'b1, 32'd0, 32'd500000000, 32'h0, 3);
    run(1'b1, -32'sd500000000, -32'sd300000000, 32'h0, 0);

    // Reset in the middle of LAUNCH
    send(1'b0, 32'h4000_0000, 32'h0, 32'h1000_0000);
    @(posedge clk); #1;
    check_bit("midrun_start_high", cordic_start, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_bit("midrun_rst_start", cordic_start, 1'b0);
    check_bit("midrun_rst_out_valid", out_valid, 1'b0);
    check_bit("midrun_rst_in_ready", in_ready, 1'b0);
    check_bit("midrun_rst_cordic_reset", cordic_reset, 1'b1);
    check_bit("midrun_rst_cordic_mode", cordic_mode, 1'b0);
    check_tol("midrun_rst_cordic_x", cordic_x, 32'd0, 0, 1'b0);
    check_tol("midrun_rst_cordic_angle", cordic_angle, 32'd0, 0, 1'b0);
    check_tol("midrun_rst_out_x", out_x, 32'd0, 0, 1'b0);
    check_tol("midrun_rst_out_y", out_y, 32'd0, 0, 1'b0);
    check_tol("midrun_rst_out_angle", out_angle, 32'd0, 0, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_bit("rerst_cordic_reset_edge1", cordic_reset, 1'b1);
    @(posedge clk); #1;
    check_bit("rerst_cordic_reset_edge2", cordic_reset, 1'b0);

    // A fresh request completes after the reset
    run(1'b0, 32'h4000_0000, 32'h0, 32'h4000_0000, 0);
    check_tol("post_rst_x", got_x, 32'd0, TOL_XY, 1'b0);
    check_tol("post_rst_y", got_y, 32'h4000_0000, TOL_XY, 1'b0);

    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expected results never appeared", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
